// File: rtl/instruction_memory_loader_pkg.sv
// Shared definitions for the instruction memory, its loader and the fetch path.
package instruction_memory_loader_pkg;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned INST_W         = 32;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned BYTE_CNT_W     = $clog2(BYTES_PER_WORD);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACCEPT = 3'd1,
    WRITE  = 3'd2,
    DONE   = 3'd3,
    ERROR  = 3'd4
  } loader_state_t;

endpackage

// File: rtl/instruction_memory_loader_serializer.sv
// Holds one accepted instruction word and presents its bytes LSB first.
module word_byte_serializer
  import instruction_memory_loader_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  load,
  input  logic [INST_W-1:0]     word_in,
  input  logic                  step,
  output logic [BYTE_CNT_W-1:0] byte_cnt,
  output logic [BYTE_W-1:0]     byte_out
);

  logic [BYTES_PER_WORD-1:0][BYTE_W-1:0] word_q;
  logic [BYTE_CNT_W-1:0]                 next_cnt_c;

  assign next_cnt_c = byte_cnt + BYTE_CNT_W'(1);

  // Latch the word on load; byte_out is the lane that is on the bus next cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      word_q   <= '0;
      byte_cnt <= '0;
      byte_out <= '0;
    end else if (load) begin
      word_q   <= word_in;
      byte_cnt <= '0;
      byte_out <= word_in[BYTE_W-1:0];
    end else if (step) begin
      byte_cnt <= next_cnt_c;
      byte_out <= word_q[next_cnt_c];
    end
  end

endmodule

// File: rtl/instruction_memory_loader.sv
// Streams 32-bit instruction words into a byte-wide, little-endian memory port.
module instruction_memory_loader
  import instruction_memory_loader_pkg::*;
#(
  parameter int unsigned       MEM_BYTES = 160,
  parameter int unsigned       ADDR_W    = 64,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              word_valid,
  input  logic [INST_W-1:0] word_data,
  input  logic              word_last,
  output logic              word_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [BYTE_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [15:0]       words_written
);

  localparam logic [ADDR_W-1:0]     WORD_BYTES = ADDR_W'(BYTES_PER_WORD);
  localparam logic [ADDR_W-1:0]     END_ADDR   = BASE_ADDR + ADDR_W'(MEM_BYTES);
  localparam logic [BYTE_CNT_W-1:0] LAST_BYTE  = BYTE_CNT_W'(BYTES_PER_WORD - 1);

  loader_state_t         state, state_n;
  logic [ADDR_W-1:0]     addr;
  logic                  last_q;
  logic [BYTE_CNT_W-1:0] byte_cnt;
  logic                  fits_c;
  logic                  load_c;
  logic                  step_c;
  logic                  byte_last_c;

  // Remaining space is compared instead of addr+4 so the sum can never wrap.
  assign fits_c      = (END_ADDR - addr) >= WORD_BYTES;
  assign byte_last_c = (byte_cnt == LAST_BYTE);

  word_byte_serializer u_ser (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (load_c),
    .word_in  (word_data),
    .step     (step_c),
    .byte_cnt (byte_cnt),
    .byte_out (mem_wdata)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  // Next-state decode plus the load/step strobes for the serializer.
  always_comb begin
    state_n = state;
    load_c  = 1'b0;
    step_c  = 1'b0;
    case (state)
      IDLE:    if (start) state_n = ACCEPT;
      ACCEPT: begin
        if (word_valid) begin
          load_c  = fits_c;
          state_n = fits_c ? WRITE : ERROR;
        end
      end
      WRITE: begin
        step_c = 1'b1;
        if (byte_last_c) state_n = last_q ? DONE : ACCEPT;
      end
      DONE:    state_n = IDLE;
      ERROR:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Registered outputs are decoded from the next state so they line up with it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr          <= BASE_ADDR;
      last_q        <= 1'b0;
      word_ready    <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      words_written <= '0;
    end else begin
      word_ready <= (state_n == ACCEPT);
      mem_we     <= (state_n == WRITE);
      busy       <= (state_n == ACCEPT) || (state_n == WRITE);
      done       <= (state_n == DONE);
      if (state == IDLE && start) begin
        addr          <= BASE_ADDR;
        words_written <= '0;
        error         <= 1'b0;
      end
      if (state == ACCEPT && word_valid && !fits_c) error <= 1'b1;
      if (load_c) begin
        last_q   <= word_last;
        mem_addr <= addr;
      end
      if (step_c) begin
        mem_addr <= mem_addr + ADDR_W'(1);
        if (byte_last_c) begin
          addr          <= addr + WORD_BYTES;
          words_written <= words_written + 16'd1;
        end
      end
    end
  end

endmodule

// File: doc/instruction_memory_loader.md
Name: instruction_memory_loader

Overview:
- Write-side counterpart of the byte-addressed, little-endian instruction memory.
- Accepts 32-bit instruction words over a valid/ready stream.
- Serialises each word into four byte writes at consecutive addresses, least significant byte at the lowest address.
- Sits between the boot/test program source and the instruction memory's byte-write port; the fetch path then reads the program back as 32-bit words.

Parameters:
- MEM_BYTES, 160, instruction memory size in bytes; must be a multiple of 4.
- ADDR_W, 64, byte address width; matches the fetch address width.
- BASE_ADDR, 0, first byte address written; must be 4-byte aligned.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a load session.
- word_valid  in  1  source presents a word.
- word_data  in  32  instruction word.
- word_last  in  1  marks the final word of the session; qualified by word_valid.
- word_ready  out  1  loader accepts a word this cycle.
- mem_we  out  1  byte write enable.
- mem_addr  out  ADDR_W  byte address.
- mem_wdata  out  8  byte data.
- busy  out  1  session in progress.
- done  out  1  one-cycle pulse when the session completes normally.
- error  out  1  sticky overflow flag.
- words_written  out  16  words fully written in the current or last session.

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0; address counter = BASE_ADDR.
- States: IDLE, ACCEPT, WRITE, DONE, ERROR.
- IDLE:
  - start=1 -> ACCEPT; addr <= BASE_ADDR; words_written <= 0; error <= 0.
  - start is ignored in every other state.
- ACCEPT:
  - word_ready=1 and busy=1.
  - Handshake occurs when word_valid and word_ready are both 1.
  - On handshake with addr+4 <= BASE_ADDR+MEM_BYTES: latch word_data and word_last; byte_cnt <= 0; -> WRITE.
  - On handshake with addr+4 > BASE_ADDR+MEM_BYTES: the word is consumed; no write is issued; -> ERROR.
- WRITE:
  - Lasts exactly 4 cycles; word_ready=0.
  - Each cycle: mem_we=1, mem_addr=addr+byte_cnt, mem_wdata=word[8*byte_cnt+7 : 8*byte_cnt].
  - After byte_cnt=3: addr <= addr+4; words_written++ (wraps at 16 bits); if latched last -> DONE, else -> ACCEPT.
- DONE: done=1 for one cycle; busy=0; -> IDLE.
- ERROR: error=1; -> IDLE. error stays high until the next accepted start or reset.
- Outputs are registered and change only on clock edges:
  - mem_we rises one cycle after the handshake.
  - Latency from handshake to first byte write is 1 cycle.
  - Throughput is 5 cycles per word with back-to-back valid.
- word_valid with word_ready=0 has no effect; the source holds the word until the handshake.
- Exact fill: the word whose last byte lands at BASE_ADDR+MEM_BYTES-1 is written normally. The next word triggers ERROR.
- word_last on the first word: one word is written, then DONE.
- Reset mid-WRITE: mem_we drops immediately (asynchronous). The partially written word remains in memory and is not counted.
- busy=1 in ACCEPT and WRITE only.

Decomposition:
- Shared package:
  - loader_state_t enum (IDLE, ACCEPT, WRITE, DONE, ERROR)
  - BYTES_PER_WORD=4
  - INST_W=32
  - BYTE_W=8
- This package is shared with the instruction memory and fetch logic.
- One natural sub-module: word_byte_serializer, which holds the latched word and byte_cnt and emits the lane-selected byte. The FSM and address logic stay in the top.

Test Plan:
- Three-word session (0x00400593, 0x00000313, 0x00000393), valid held high, last on word 3:
  - writes 93,05,40,00 then 13,03,00,00 then 93,03,00,00 to addresses 0..11;
  - 5 cycles per word; done pulses once; words_written=3.
- Backpressure: valid toggles 1,0,0,1 with gaps between words -> no mem_we during gaps; byte order and addresses unchanged; word_ready never high in WRITE.
- Overflow, MEM_BYTES=160: stream 41 words without last -> bytes 0..159 written; word 41 consumed with no mem_we; error=1; words_written=40; no done pulse.
- start pulsed during WRITE of word 2 -> ignored; session continues; addresses keep incrementing from 4.
- reset_n driven low during the byte 2 write of word 1 -> mem_we=0 in the same cycle; all outputs 0. A new start rewrites from BASE_ADDR; words_written restarts at 0.
- BASE_ADDR=16, single word 0xFA0004E3 with last -> bytes E3,04,00,FA written to addresses 16..19; done pulse; error=0.
